// File: rtl/board_pkg.sv
// Shared board geometry, colour codes and stream FSM states.
// Imported by the row streamer and by the graphics stage.
package board_pkg;

   localparam int ROWS   = 20;
   localparam int COLS   = 10;
   localparam int CELL_W = 3;
   localparam int ROW_W  = COLS * CELL_W;
   localparam int IDX_W  = 5;

   localparam logic [CELL_W-1:0] CLR_EMPTY  = 3'd0;
   localparam logic [CELL_W-1:0] CLR_CYAN   = 3'd1;
   localparam logic [CELL_W-1:0] CLR_YELLOW = 3'd2;
   localparam logic [CELL_W-1:0] CLR_PURPLE = 3'd3;
   localparam logic [CELL_W-1:0] CLR_GREEN  = 3'd4;
   localparam logic [CELL_W-1:0] CLR_RED    = 3'd5;
   localparam logic [CELL_W-1:0] CLR_BLUE   = 3'd6;
   localparam logic [CELL_W-1:0] CLR_ORANGE = 3'd7;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

endpackage

// File: rtl/board_row_streamer_if.sv
// Game-logic write bus and renderer row bus of the board streamer.
// master = game logic / renderer side, slave = the streamer.
interface board_row_streamer_if;

   logic                          wr_en;
   logic [board_pkg::IDX_W-1:0]   wr_row;
   logic [board_pkg::ROW_W-1:0]   wr_data;
   logic                          clear;
   logic                          commit;
   logic [board_pkg::ROW_W-1:0]   oData;
   logic [board_pkg::IDX_W-1:0]   oIndex;
   logic                          oVal;

   modport master (
      output wr_en, wr_row, wr_data, clear, commit,
      input  oData, oIndex, oVal
   );

   modport slave (
      input  wr_en, wr_row, wr_data, clear, commit,
      output oData, oIndex, oVal
   );

endinterface

// File: rtl/board_store.sv
// Working board plus frame snapshot, with an async snapshot read port.
// The snapshot captures pre-edge working rows, so a same-edge write misses it.
module board_store #(
   parameter int ROWS  = board_pkg::ROWS,
   parameter int ROW_W = board_pkg::ROW_W,
   parameter int IDX_W = board_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_row_i,
   input  logic [ROW_W-1:0] wr_data_i,
   input  logic             clear_i,
   input  logic             snap_i,
   input  logic [IDX_W-1:0] rd_row_i,
   output logic [ROW_W-1:0] rd_data_o
);

   logic [ROW_W-1:0] work_q [ROWS];
   logic [ROW_W-1:0] snap_q [ROWS];

   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '{default: '0};
         snap_q <= '{default: '0};
      end else begin
         if (snap_i) begin
            snap_q <= work_q;
         end
         if (clear_i) begin
            work_q <= '{default: '0};
         end else if (wr_en_i && (wr_row_i < IDX_W'(ROWS))) begin
            work_q[wr_row_i] <= wr_data_i;
         end
      end
   end

   always_comb begin
      rd_data_o = '0;
      if (rd_row_i < IDX_W'(ROWS)) begin
         rd_data_o = snap_q[rd_row_i];
      end
   end

endmodule

// File: rtl/board_row_streamer.sv
// Streams a committed board snapshot row by row once per vertical blank.
// Owns the stream FSM, commit tracking, vblank edge detect and output regs.
module board_row_streamer #(
   parameter int ROWS   = board_pkg::ROWS,
   parameter int COLS   = board_pkg::COLS,
   parameter int CELL_W = board_pkg::CELL_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vblank,
   output logic                 busy,
   board_row_streamer_if.slave  bus
);

   import board_pkg::*;

   localparam int RW = COLS * CELL_W;

   state_t           state_q, state_d;
   logic             pend_q, pend_d;
   logic             vb_q;
   logic [IDX_W-1:0] row_q, row_d;
   logic [RW-1:0]    odata_q, odata_d;
   logic [IDX_W-1:0] oidx_q, oidx_d;
   logic             oval_q, oval_d;
   logic             vb_rise;
   logic             start;
   logic [RW-1:0]    rd_data;

   board_store #(
      .ROWS  (ROWS),
      .ROW_W (RW),
      .IDX_W (IDX_W)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (bus.wr_en),
      .wr_row_i  (bus.wr_row),
      .wr_data_i (bus.wr_data),
      .clear_i   (bus.clear),
      .snap_i    (start),
      .rd_row_i  (row_q),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         vb_q    <= 1'b0;
         row_q   <= '0;
         odata_q <= '0;
         oidx_q  <= '0;
         oval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         vb_q    <= vblank;
         row_q   <= row_d;
         odata_q <= odata_d;
         oidx_q  <= oidx_d;
         oval_q  <= oval_d;
      end
   end

   always_comb begin
      vb_rise = vblank & ~vb_q;
      start   = 1'b0;
      state_d = state_q;
      row_d   = row_q;
      pend_d  = pend_q;
      odata_d = '0;
      oidx_d  = '0;
      oval_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (vb_rise && (pend_q || bus.commit)) begin
               start   = 1'b1;
               state_d = STREAM;
               row_d   = '0;
            end
         end
         STREAM: begin
            odata_d = rd_data;
            oidx_d  = row_q;
            oval_d  = 1'b1;
            row_d   = row_q + 1'b1;
            if (row_q == IDX_W'(ROWS - 1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // a commit landing on the start edge is already in this snapshot
      if (start) begin
         pend_d = 1'b0;
      end else if (bus.commit) begin
         pend_d = 1'b1;
      end
   end

   assign bus.oData  = odata_q;
   assign bus.oIndex = oidx_q;
   assign bus.oVal   = oval_q;
   assign busy       = oval_q;

endmodule

// File: doc/board_row_streamer.md
# board_row_streamer

Holds the live 20×10 Tetris board written by game logic. Once per displayed frame, it streams a consistent snapshot of that board row by row into the custom graphics stage, which consumes a 30-bit row with a 5-bit row index. It sits between the game-logic core, which writes cells and signals commit, and the graphics renderer. A stream runs only during vertical blank and only when game logic has committed an update, so the renderer never shows a half-updated board.

## Interface
Parameters:
- ROWS, 20, board rows; row 0 is the top row.
- COLS, 10, board columns.
- CELL_W, 3, bits per cell colour code; 0 = empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- wr_en  in  1  write one full row into the working board.
- wr_row  in  5  row index for the write; values ≥ ROWS are ignored.
- wr_data  in  30  row contents; column c occupies bits [3c+2:3c], column 0 is leftmost.
- clear  in  1  one-cycle pulse that zeroes the working board.
- commit  in  1  one-cycle pulse: the working board is frame-complete.
- vblank  in  1  level from display timing; high during vertical blank.
- oData  out  30  row data for the graphics stage (its iData).
- oIndex  out  5  row index for the graphics stage (its index).
- oVal  out  1  oData/oIndex valid this cycle.
- busy  out  1  high while the block is in STREAM.

## Operation
- Working array: ROWS×30 registers.
  - wr_en with wr_row < ROWS writes the row at the clock edge.
  - clear zeroes all rows.
  - If wr_en and clear arrive together, clear wins.
  - Writes are always accepted, including during STREAM.
- Snapshot array: ROWS×30 registers, loaded from the working array on the stream-start edge. The snapshot takes pre-edge values, so a write on that same edge goes to the working array only.
- pending flag: set by commit and cleared on stream start. A commit on the start edge is absorbed, and pending stays 0. A commit during STREAM sets pending for the next frame.
- vblank_q holds vblank registered one cycle. vb_rise = vblank & ~vblank_q.
- FSM:
  - IDLE → STREAM when vb_rise & (pending | commit). On that edge: snapshot ← working, row counter ← 0.
  - STREAM: each cycle output snapshot[row]. Increment the row counter; after ROWS-1, go to IDLE.
  - STREAM never restarts while vblank remains high. A new vb_rise is required.
- vb_rise during STREAM is ignored; it cannot occur at valid timing.
- If vb_rise occurs without pending, there is no stream. The graphics stage keeps the previous frame.

## Timing
- Reset values:
  - oData = 0, oIndex = 0, oVal = 0, busy = 0.
  - state = IDLE, pending = 0, vblank_q = 0.
  - Working and snapshot arrays are all zero.
- Latency:
  - Let the start edge be at cycle T.
  - Outputs are registered. oVal is high at cycles T+1 … T+ROWS, with oIndex = 0 … ROWS-1 in order.
  - oVal is low at T+ROWS+1.
- busy equals oVal.
- Back-to-back rows: no gaps, one row per cycle.
- Write-to-display: a row written at or before the edge preceding the start edge appears in that stream.
- Reset mid-stream: at the next edge, oVal = 0 and the FSM goes to IDLE. The stream is not resumed, and both arrays are zeroed.

## Structure
- Shared package board_pkg:
  - ROWS, COLS, CELL_W, ROW_W (= COLS*CELL_W), IDX_W (= 5).
  - Cell colour code constants.
  - state_t enum {IDLE, STREAM}.
  - Both board_row_streamer and the graphics stage import it.
- Sub-module board_store: the working and snapshot arrays, with write/clear/snapshot controls and an asynchronous row read port. The top level keeps the FSM, pending logic, edge detection and output registers.

## Test plan
- Reset held 3 cycles → all outputs 0. Then vb_rise without any commit → oVal stays 0 for 40 cycles.
- Write row 5 = 30'h0924_9249 (all cells 001), commit, then vb_rise → oVal high for exactly 20 cycles, oIndex 0..19. The oIndex = 5 cycle carries 30'h0924_9249; all other rows carry 0.
- With the board from the previous scenario and commit pending, keep vblank high for 50 cycles after the stream → exactly one 20-cycle burst. A second vb_rise without a new commit → no burst.
- During a stream, write row 3 = 30'h3FFF_FFFF and commit → the current burst shows row 3 = 0. The next vb_rise burst shows 30'h3FFF_FFFF at oIndex 3.
- wr_en with wr_row = 20 and 31, data all ones; then commit and vb_rise → every streamed row is 0.
- Assert rst while oIndex = 7 → next cycle oVal = 0, busy = 0. After commit and vb_rise → full 20-row burst of zeros.
